// File: rtl/loan_uart_pkg.sv
// loan_uart shared constants: loan-I/O pin map and UART FSM states.
// Build option LOAN_UART_PARITY_EN adds an even-parity bit to each frame.
package loan_uart_pkg;

  localparam int LOAN_W     = 67;
  localparam int LOANIO_RXD = 49;
  localparam int LOANIO_TXD = 50;
  localparam int LOANIO_LED = 53;
  localparam int LOANIO_KEY = 54;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP,
    RX_WAIT_HIGH
  } rx_state_e;

endpackage

// File: rtl/uart_rx_core.sv
// UART receiver: RXD synchronizer, mid-bit sampling FSM, byte/error strobes.
// LOAN_UART_PARITY_EN enables the even-parity check before the stop bit.
module uart_rx_core
  import loan_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rxd_pin,
  output logic       byte_stb,
  output logic       err_stb,
  output logic [7:0] data
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);

  logic [1:0]    sync;
  logic          rxd;
  rx_state_e     state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    bit_idx, bit_n;
  logic [7:0]    sh, sh_n;
  logic          par_ok, par_ok_n;

  assign rxd  = sync[1];
  assign data = sh;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync    <= 2'b11;
      state   <= RX_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      sh      <= '0;
      par_ok  <= 1'b1;
    end else begin
      sync    <= {sync[0], rxd_pin};
      state   <= state_n;
      cnt     <= cnt_n;
      bit_idx <= bit_n;
      sh      <= sh_n;
      par_ok  <= par_ok_n;
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt + CW'(1);
    bit_n    = bit_idx;
    sh_n     = sh;
    par_ok_n = par_ok;
    byte_stb = 1'b0;
    err_stb  = 1'b0;
    unique case (state)
      RX_IDLE: begin
        cnt_n    = '0;
        par_ok_n = 1'b1;
        if (!rxd) state_n = RX_START;
      end
      // a start bit that is high again at mid-bit was only a glitch
      RX_START: if (cnt == HALF_END) begin
        cnt_n   = '0;
        bit_n   = '0;
        state_n = rxd ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (cnt == BIT_END) begin
        cnt_n = '0;
        sh_n  = {rxd, sh[7:1]};
        bit_n = bit_idx + 3'd1;
        if (bit_idx == 3'd7) begin
`ifdef LOAN_UART_PARITY_EN
          state_n = RX_PARITY;
`else
          state_n = RX_STOP;
`endif
        end
      end
      RX_PARITY: if (cnt == BIT_END) begin
        cnt_n    = '0;
        par_ok_n = ~(^sh ^ rxd);
        state_n  = RX_STOP;
      end
      RX_STOP: if (cnt == BIT_END) begin
        cnt_n = '0;
        if (rxd && par_ok) begin
          byte_stb = 1'b1;
          state_n  = RX_IDLE;
        end else begin
          err_stb = 1'b1;
          state_n = rxd ? RX_IDLE : RX_WAIT_HIGH;
        end
      end
      RX_WAIT_HIGH: begin
        cnt_n = '0;
        if (rxd) state_n = RX_IDLE;
      end
      default: state_n = RX_IDLE;
    endcase
  end

endmodule

// File: rtl/loan_uart.sv
// HPS loan-I/O UART: TX FSM, RX holding register, activity LED, pin map.
// Define LOAN_UART_PARITY_EN for 8E1 framing; default is 8N1.
module loan_uart
  import loan_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int LED_HOLD     = 2500000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [LOAN_W-1:0] loan_io_in,
  output logic [LOAN_W-1:0] loan_io_out,
  output logic [LOAN_W-1:0] loan_io_oe,
  input  logic [7:0]        tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [7:0]        rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              rx_overrun,
  output logic              rx_frame_err,
  output logic              key_n
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int LW = $clog2(LED_HOLD + 1);
  localparam logic [CW-1:0] BIT_END = CW'(CLKS_PER_BIT - 1);

  tx_state_e     tx_state, tx_state_n;
  logic [CW-1:0] tx_cnt, tx_cnt_n;
  logic [2:0]    tx_bit, tx_bit_n;
  logic [7:0]    tx_sh, tx_sh_n;
  logic          tx_par, tx_par_n;
  logic          txd;
  logic          rx_stb, rx_err;
  logic [7:0]    rx_byte;
  logic [1:0]    key_sync;
  logic [LW-1:0] led_cnt;
  logic          unused_in;

  assign tx_ready  = (tx_state == TX_IDLE);
  assign key_n     = key_sync[1];
  assign unused_in = ^{loan_io_in[LOAN_W-1:LOANIO_KEY+1],
                       loan_io_in[LOANIO_KEY-1:LOANIO_RXD+1],
                       loan_io_in[LOANIO_RXD-1:0]};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_sh    <= '0;
      tx_par   <= 1'b0;
    end else begin
      tx_state <= tx_state_n;
      tx_cnt   <= tx_cnt_n;
      tx_bit   <= tx_bit_n;
      tx_sh    <= tx_sh_n;
      tx_par   <= tx_par_n;
    end
  end

  always_comb begin
    tx_state_n = tx_state;
    tx_cnt_n   = (tx_cnt == BIT_END) ? '0 : tx_cnt + CW'(1);
    tx_bit_n   = tx_bit;
    tx_sh_n    = tx_sh;
    tx_par_n   = tx_par;
    txd        = 1'b1;
    unique case (tx_state)
      TX_IDLE: begin
        tx_cnt_n = '0;
        if (tx_valid) begin
          tx_state_n = TX_START;
          tx_sh_n    = tx_data;
          tx_par_n   = ^tx_data;
        end
      end
      TX_START: begin
        txd = 1'b0;
        if (tx_cnt == BIT_END) begin
          tx_state_n = TX_DATA;
          tx_bit_n   = '0;
        end
      end
      TX_DATA: begin
        txd = tx_sh[0];
        if (tx_cnt == BIT_END) begin
          tx_sh_n  = tx_sh >> 1;
          tx_bit_n = tx_bit + 3'd1;
          if (tx_bit == 3'd7) begin
`ifdef LOAN_UART_PARITY_EN
            tx_state_n = TX_PARITY;
`else
            tx_state_n = TX_STOP;
`endif
          end
        end
      end
      TX_PARITY: begin
        txd = tx_par;
        if (tx_cnt == BIT_END) tx_state_n = TX_STOP;
      end
      TX_STOP: if (tx_cnt == BIT_END) tx_state_n = TX_IDLE;
      default: tx_state_n = TX_IDLE;
    endcase
  end

  uart_rx_core #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk     (clk),
    .reset_n (reset_n),
    .rxd_pin (loan_io_in[LOANIO_RXD]),
    .byte_stb(rx_stb),
    .err_stb (rx_err),
    .data    (rx_byte)
  );

  // a same-cycle handshake frees the entry for the incoming byte
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_valid     <= 1'b0;
      rx_data      <= '0;
      rx_overrun   <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      rx_overrun   <= rx_stb && rx_valid && !rx_ready;
      rx_frame_err <= rx_err;
      if (rx_stb && (!rx_valid || rx_ready)) begin
        rx_data  <= rx_byte;
        rx_valid <= 1'b1;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      key_sync <= 2'b11;
      led_cnt  <= '0;
    end else begin
      key_sync <= {key_sync[0], loan_io_in[LOANIO_KEY]};
      if ((tx_valid && tx_ready) || rx_stb)
        led_cnt <= LW'(LED_HOLD);
      else if (led_cnt != '0)
        led_cnt <= led_cnt - LW'(1);
    end
  end

  always_comb begin
    loan_io_out             = '0;
    loan_io_out[LOANIO_TXD] = txd;
    loan_io_out[LOANIO_LED] = (led_cnt != '0);
    loan_io_oe              = '0;
    loan_io_oe[LOANIO_TXD]  = 1'b1;
    loan_io_oe[LOANIO_LED]  = 1'b1;
  end

endmodule

// File: tb/tb_loan_uart.sv
// Bench for loan_uart: RX frame table with scoreboard, TX waveform,
// overrun, glitch, key, pin map and mid-frame reset sequences.
module tb_loan_uart;

  localparam int CPB  = 8;
  localparam int HOLD = 40;
`ifdef LOAN_UART_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        rxd = 1'b1;
  logic        key = 1'b1;
  logic [66:0] loan_io_in, loan_io_out, loan_io_oe;
  logic [7:0]  tx_data = 8'h00;
  logic        tx_valid = 1'b0;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready = 1'b0;
  logic        rx_overrun, rx_frame_err, key_n;

  int          n_tests = 0;
  int          n_fail = 0;
  int          err_cnt = 0;
  int          ovr_cnt = 0;
  logic [7:0]  sb[$];

  typedef struct {
    logic [7:0] d;
    logic       stop;
    logic       bad_par;
    logic       exp_valid;
    int         exp_err;
  } rx_vec_t;

  rx_vec_t vecs[$];

  assign loan_io_in = (67'(key) << 54) | (67'(rxd) << 49);

  always #5 clk = ~clk;

  loan_uart #(
    .CLKS_PER_BIT(CPB),
    .LED_HOLD    (HOLD)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .loan_io_in  (loan_io_in),
    .loan_io_out (loan_io_out),
    .loan_io_oe  (loan_io_oe),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .rx_overrun  (rx_overrun),
    .rx_frame_err(rx_frame_err),
    .key_n       (key_n)
  );

  task automatic check(input string name, input logic [95:0] act,
                       input logic [95:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  always @(negedge clk) begin
    #2;
    if (rx_frame_err) err_cnt++;
    if (rx_overrun) ovr_cnt++;
    if (rx_valid && rx_ready) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL rx_unexpected: got %0h expected none", rx_data);
      end else begin
        check("rx_byte", rx_data, sb.pop_front());
      end
    end
  end

  task automatic send_rx(input logic [7:0] d, input logic stop,
                         input logic bad_par, input int ready_at);
    logic [10:0] fr;
    int idx;
    idx = 0;
`ifdef LOAN_UART_PARITY_EN
    fr = {stop, (^d) ^ bad_par, d, 1'b0};
`else
    fr = {bad_par, stop, d, 1'b0};
`endif
    for (int b = 0; b < NBITS; b++) begin
      for (int c = 0; c < CPB; c++) begin
        rxd = fr[b];
        if (idx == ready_at) rx_ready = 1'b1;
        idx++;
        @(negedge clk);
      end
    end
    rxd = 1'b1;
    tick(2 * CPB);
  endtask

  initial begin
    logic [66:0] oe_exp;
    logic [66:0] out_idle;
    logic [87:0] got_w, exp_w;
    logic [10:0] fr;
    int rdy_bad, e0, o0;

    vecs.push_back('{8'h3C, 1'b1, 1'b0, 1'b1, 0});
    vecs.push_back('{8'hFF, 1'b0, 1'b0, 1'b0, 1});
    vecs.push_back('{8'h5A, 1'b1, 1'b0, 1'b1, 0});
    vecs.push_back('{8'h00, 1'b1, 1'b0, 1'b1, 0});
    vecs.push_back('{8'h81, 1'b1, 1'b0, 1'b1, 0});
`ifdef LOAN_UART_PARITY_EN
    vecs.push_back('{8'h77, 1'b1, 1'b1, 1'b0, 1});
    vecs.push_back('{8'h12, 1'b1, 1'b0, 1'b1, 0});
`endif

    oe_exp   = (67'd1 << 50) | (67'd1 << 53);
    out_idle = 67'd1 << 50;

    tick(3);
    check("rst_tx_ready", tx_ready, 1);
    check("rst_io_out", loan_io_out, out_idle);
    check("rst_io_oe", loan_io_oe, oe_exp);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_rx_data", rx_data, 0);
    check("rst_overrun", rx_overrun, 0);
    check("rst_frame_err", rx_frame_err, 0);
    check("rst_key_n", key_n, 1);
    reset_n = 1'b1;
    tick(2);

    tx_data  = 8'hA5;
    tx_valid = 1'b1;
    check("tx_ready_pre", tx_ready, 1);
    tick(1);
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    check("led_on", loan_io_out[53], 1);
    got_w   = '0;
    exp_w   = '0;
    rdy_bad = 0;
`ifdef LOAN_UART_PARITY_EN
    fr = {1'b1, ^8'hA5, 8'hA5, 1'b0};
`else
    fr = {1'b0, 1'b1, 8'hA5, 1'b0};
`endif
    for (int i = 0; i < NBITS * CPB; i++) begin
      got_w[i] = loan_io_out[50];
      exp_w[i] = fr[i / CPB];
      if (tx_ready) rdy_bad++;
      tick(1);
    end
    check("tx_wave", got_w, exp_w);
    check("tx_ready_low", rdy_bad, 0);
    check("tx_ready_post", tx_ready, 1);
    check("led_off", loan_io_out[53], 0);

    key = 1'b0;
    tick(1);
    check("key_n_1cyc", key_n, 1);
    tick(1);
    check("key_n_2cyc", key_n, 0);
    key = 1'b1;
    tick(3);

    rx_ready = 1'b1;
    e0  = err_cnt;
    rxd = 1'b0;
    tick(CPB / 4);
    rxd = 1'b1;
    tick(3 * CPB);
    check("glitch_valid", rx_valid, 0);
    check("glitch_err", err_cnt - e0, 0);
    check("io_oe", loan_io_oe, oe_exp);

    foreach (vecs[i]) begin
      e0 = err_cnt;
      if (vecs[i].exp_valid) sb.push_back(vecs[i].d);
      send_rx(vecs[i].d, vecs[i].stop, vecs[i].bad_par, -1);
      check("rx_err_cnt", err_cnt - e0, vecs[i].exp_err);
      check("rx_sb_drain", sb.size(), 0);
    end

    rx_ready = 1'b0;
    o0 = ovr_cnt;
    e0 = err_cnt;
    sb.push_back(8'h11);
    send_rx(8'h11, 1'b1, 1'b0, -1);
    send_rx(8'h22, 1'b1, 1'b0, -1);
    check("ovr_valid", rx_valid, 1);
    check("ovr_data", rx_data, 8'h11);
    check("ovr_count", ovr_cnt - o0, 1);
    check("ovr_err", err_cnt - e0, 0);
    rx_ready = 1'b1;
    tick(1);
    check("rx_clear", rx_valid, 0);
    check("ovr_sb_drain", sb.size(), 0);

    rx_ready = 1'b0;
    o0 = ovr_cnt;
    sb.push_back(8'h33);
    send_rx(8'h33, 1'b1, 1'b0, -1);
    check("same_pre_valid", rx_valid, 1);
    sb.push_back(8'h44);
    send_rx(8'h44, 1'b1, 1'b0, (NBITS - 1) * CPB + 6);
    check("same_no_ovr", ovr_cnt - o0, 0);
    check("same_sb_drain", sb.size(), 0);
    check("same_valid_clr", rx_valid, 0);

    tx_data  = 8'h00;
    tx_valid = 1'b1;
    tick(1);
    tx_valid = 1'b0;
    tick(30);
    check("midtx_txd_low", loan_io_out[50], 0);
    reset_n = 1'b0;
    #1;
    check("midrst_txd", loan_io_out[50], 1);
    check("midrst_ready", tx_ready, 1);
    tick(2);
    reset_n = 1'b1;
    tick(2);
    check("post_rst_ready", tx_ready, 1);
    check("post_rst_valid", rx_valid, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
